// File: rtl/hci_tcdm_bank_target.sv
// hci_tcdm_bank_target: single-cycle TCDM bank with test-and-set alias and optional
// grant stalling (HCI_TCDM_BANK_STALL_EN).
module hci_tcdm_bank_target #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int IW = 8,
  parameter int ADDR_MEM_WIDTH = 11,
  parameter int TS_BIT = 20
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_i,
  output logic          gnt_o,
  input  logic [AW-1:0] add_i,
  input  logic          wen_i,
  input  logic [DW-1:0] data_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [IW-1:0] id_i,
  output logic          r_valid_o,
  output logic [DW-1:0] r_data_o,
  output logic [IW-1:0] r_id_o,
  output logic          r_opc_o
);
  typedef enum logic {IDLE, TAS_WR} state_t;
  state_t state, state_n;
  logic [DW-1:0] mem [2**ADDR_MEM_WIDTH];
  logic [ADDR_MEM_WIDTH-1:0] idx, tas_idx;
  logic acc, aligned, tas, stall;
  logic r_valid_q, r_opc_q;
  logic [DW-1:0] r_data_q;
  logic [IW-1:0] r_id_q;
  assign idx = add_i[ADDR_MEM_WIDTH+1:2];
`ifdef HCI_TCDM_BANK_STALL_EN
  logic [7:0] lfsr;
  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr <= 8'hA5;
    else lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
  assign stall = lfsr[1:0] == 2'b00;
`else
  assign stall = 1'b0;
`endif
  assign gnt_o = !rst_i && state == IDLE && !stall;
  assign acc = req_i && gnt_o;
  assign aligned = add_i[1:0] == 2'b00;
  assign tas = acc && aligned && wen_i && add_i[TS_BIT];
  always_comb begin
    state_n = IDLE;
    if (state == IDLE && tas) state_n = TAS_WR;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid_q <= 1'b0;
      r_opc_q <= 1'b0;
      r_data_q <= '0;
      r_id_q <= '0;
    end else begin
      r_valid_q <= acc;
      r_opc_q <= acc && !aligned;
      r_data_q <= (acc && aligned && wen_i) ? mem[idx] : '0;
      r_id_q <= acc ? id_i : '0;
    end
  end
  // Storage is never reset; a reset during TAS_WR drops the pending all-ones write.
  always_ff @(posedge clk_i) begin
    if (tas) tas_idx <= idx;
    if (state == TAS_WR && !rst_i) mem[tas_idx] <= '1;
    else if (acc && aligned && !wen_i)
      for (int b = 0; b < DW/8; b++)
        if (be_i[b]) mem[idx][8*b +: 8] <= data_i[8*b +: 8];
  end
  // Outputs are masked while reset is high so a response due in that cycle is suppressed.
  assign r_valid_o = r_valid_q && !rst_i;
  assign r_opc_o = r_opc_q && !rst_i;
  assign r_data_o = rst_i ? '0 : r_data_q;
  assign r_id_o = rst_i ? '0 : r_id_q;
endmodule

// File: tb/tb_hci_tcdm_bank_target.sv
// tb_hci_tcdm_bank_target: directed self-checking bench for hci_tcdm_bank_target.
module tb_hci_tcdm_bank_target;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0;
  logic gnt;
  logic [31:0] add = '0;
  logic wen = 1'b1;
  logic [31:0] data = '0;
  logic [3:0] be = '0;
  logic [7:0] id = '0;
  logic r_valid, r_opc;
  logic [31:0] r_data;
  logic [7:0] r_id;
  int checks = 0;
  int errors = 0;

  hci_tcdm_bank_target dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .add_i(add), .wen_i(wen),
    .data_i(data), .be_i(be), .id_i(id), .r_valid_o(r_valid), .r_data_o(r_data),
    .r_id_o(r_id), .r_opc_o(r_opc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] b, input logic [7:0] i);
    req = 1'b1; add = a; wen = w; data = d; be = b; id = i;
    step();
    req = 1'b0;
  endtask

  task automatic rsp(input string tag, input logic [31:0] d, input logic [7:0] i, input logic o);
    chk({tag, "_valid"}, {31'd0, r_valid}, 32'd1);
    chk({tag, "_data"}, r_data, d);
    chk({tag, "_id"}, {24'd0, r_id}, {24'd0, i});
    chk({tag, "_opc"}, {31'd0, r_opc}, {31'd0, o});
  endtask

  initial begin
    repeat (3) step();
    chk("rst_gnt", {31'd0, gnt}, 32'd0);
    chk("rst_valid", {31'd0, r_valid}, 32'd0);
    chk("rst_data", r_data, 32'd0);
    chk("rst_id", {24'd0, r_id}, 32'd0);
    chk("rst_opc", {31'd0, r_opc}, 32'd0);
    rst = 1'b0;
`ifdef HCI_TCDM_BANK_STALL_EN
    begin
      logic [7:0] m = 8'hA5;
      logic prev = 1'b0;
      logic [7:0] prev_id = '0;
      int got = 0, exp_cnt = 0;
      req = 1'b1; wen = 1'b1; add = 32'h40; be = 4'hF;
      for (int k = 0; k < 256; k++) begin
        id = k[7:0];
        #1;
        if (m[1:0] != 2'b00) exp_cnt++;
        if (gnt) got++;
        chk("stall_gnt", {31'd0, gnt}, {31'd0, m[1:0] != 2'b00});
        chk("stall_valid", {31'd0, r_valid}, {31'd0, prev});
        if (prev) chk("stall_id", {24'd0, r_id}, {24'd0, prev_id});
        prev = gnt; prev_id = id;
        m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
        step();
      end
      req = 1'b0;
      chk("stall_count", got, exp_cnt);
    end
`else
    #1;
    chk("rel_gnt", {31'd0, gnt}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      chk("idle_valid", {31'd0, r_valid}, 32'd0);
      step();
    end
    issue(32'h10, 1'b0, 32'h0, 4'hF, 8'd1);
    rsp("clr", 32'h0, 8'd1, 1'b0);
    issue(32'h10, 1'b0, 32'hDEADBEEF, 4'b0101, 8'd2);
    rsp("wr_be", 32'h0, 8'd2, 1'b0);
    issue(32'h10, 1'b1, 32'h0, 4'h0, 8'd3);
    rsp("rd_be", 32'h00AD00EF, 8'd3, 1'b0);
    issue(32'h10, 1'b0, 32'h12345678, 4'hF, 8'd4);
    issue(32'h0010_0010, 1'b1, 32'h0, 4'h0, 8'd5);
    rsp("tas", 32'h12345678, 8'd5, 1'b0);
    chk("tas_gnt_n1", {31'd0, gnt}, 32'd0);
    step();
    chk("tas_gnt_n2", {31'd0, gnt}, 32'd1);
    chk("tas_no_rsp", {31'd0, r_valid}, 32'd0);
    issue(32'h10, 1'b1, 32'h0, 4'h0, 8'd6);
    rsp("tas_after", 32'hFFFFFFFF, 8'd6, 1'b0);
    issue(32'h13, 1'b0, 32'h0, 4'hF, 8'd7);
    rsp("mis_wr", 32'h0, 8'd7, 1'b1);
    issue(32'h10, 1'b1, 32'h0, 4'h0, 8'd8);
    rsp("mis_rb", 32'hFFFFFFFF, 8'd8, 1'b0);
    issue(32'h20, 1'b0, 32'h5, 4'hF, 8'd9);
    issue(32'h0010_0020, 1'b1, 32'h0, 4'h0, 8'd10);
    rst = 1'b1;
    #1;
    chk("rst_sup_valid", {31'd0, r_valid}, 32'd0);
    chk("rst_sup_data", r_data, 32'd0);
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_rel_valid", {31'd0, r_valid}, 32'd0);
    chk("rst_rel_gnt", {31'd0, gnt}, 32'd1);
    issue(32'h20, 1'b1, 32'h0, 4'h0, 8'd11);
    rsp("rst_abort", 32'h5, 8'd11, 1'b0);
    issue(32'h0010_0024, 1'b0, 32'hCAFEF00D, 4'hF, 8'd12);
    rsp("ts_wr", 32'h0, 8'd12, 1'b0);
    chk("ts_wr_gnt", {31'd0, gnt}, 32'd1);
    issue(32'h24, 1'b1, 32'h0, 4'h0, 8'd13);
    rsp("ts_wr_rb", 32'hCAFEF00D, 8'd13, 1'b0);
    step();
    chk("final_idle", {31'd0, r_valid}, 32'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
